// File: rtl/accu_display.sv
// accu_display: four-digit, common-anode, multiplexed seven-segment driver
// for the accumulator result and the FSM state code.
//
// Digit layout (an[0] is the rightmost digit):
//   idx0 = out low nibble, idx1 = out high nibble, idx2 = blank, idx3 = state.
//
// Inputs are captured into shadow registers once per scan frame, on the
// idx 3->0 slot boundary, so a digit never shows half of an update.
// Each slot ends with one cycle where all anodes are off, so the next
// digit's segment pattern never bleeds onto the previous digit.
// When the captured state code changes, the decimal point on the state
// digit stays lit for FLASH_FRAMES frames.
//
// Optional build macro ACCU_DISPLAY_LEADING_ZERO_BLANK_EN: when it is
// defined, idx1 is blanked whenever the high nibble of the result is zero.
// The anode is still driven during that slot. When it is undefined, idx1
// always shows its hex value.
//
// Outputs are registered, and every flop clears asynchronously on reset.

module accu_display #(
  parameter int REFRESH_DIV  = 50000,  // clocks per digit slot, >= 2
  parameter int FLASH_FRAMES = 8       // frames the dp stays lit, 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_value,
  input  logic [3:0] state_value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int                CNT_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]        FLASH_LOAD = 8'(FLASH_FRAMES);
  localparam logic [6:0]        SEG_BLANK  = 7'h7F;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       idx;
  logic [7:0]       shadow_out;
  logic [3:0]       shadow_state;
  logic [7:0]       flash_cnt;

  logic             tick;
  logic             frame_end;
  logic [6:0]       digit_seg;
  logic             digit_dp;

  // Segment encoding, active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = SEG_BLANK;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Detect the last cycle of a slot, and the last slot of a frame.
  always_comb begin
    tick      = (refresh_cnt == CNT_LAST);
    frame_end = tick && (idx == 2'd3);
  end

  // Choose the segment pattern and dp level for the digit in the current slot.
  always_comb begin
    digit_seg = SEG_BLANK;
    digit_dp  = 1'b1;
    case (idx)
      2'd0: digit_seg = hex_to_seg(shadow_out[3:0]);
`ifdef ACCU_DISPLAY_LEADING_ZERO_BLANK_EN
      2'd1: digit_seg = (shadow_out[7:4] == 4'h0) ? SEG_BLANK
                                                  : hex_to_seg(shadow_out[7:4]);
`else
      2'd1: digit_seg = hex_to_seg(shadow_out[7:4]);
`endif
      2'd2: digit_seg = SEG_BLANK;
      2'd3: digit_seg = hex_to_seg(shadow_state);
      default: digit_seg = SEG_BLANK;
    endcase
    if ((idx == 2'd3) && (flash_cnt != 8'd0)) begin
      digit_dp = 1'b0;
    end
  end

  // Slot timer: counts 0..REFRESH_DIV-1 and wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Step to the next digit at the end of each slot, wrapping from 3 to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Drive the display. The tick cycle blanks everything so the anode change
  // happens while all segments are off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (tick) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= digit_seg;
      dp  <= digit_dp;
    end
  end

  // Capture a frame snapshot, and arm or count down the state-change flash.
  // A change seen on the capture that would have ended the flash re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_out   <= 8'h00;
      shadow_state <= 4'h0;
      flash_cnt    <= 8'd0;
    end else if (frame_end) begin
      shadow_out   <= out_value;
      shadow_state <= state_value;
      if (state_value != shadow_state) begin
        flash_cnt <= FLASH_LOAD;
      end else if (flash_cnt != 8'd0) begin
        flash_cnt <= flash_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_accu_display.sv
// Directed bench for accu_display with REFRESH_DIV=4 and FLASH_FRAMES=2.
// The bench counts clock edges from each reset release, so it knows the slot
// and frame position without looking at the DUT. With REFRESH_DIV=4, edge n
// shows idx ((n-1)/4)%4, every fourth edge is a blank cycle, and a capture
// happens on every edge that is a multiple of 16.

module tb_accu_display;

  localparam int REFRESH_DIV  = 4;
  localparam int FLASH_FRAMES = 2;

`ifdef ACCU_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_value;
  logic [3:0] state_value;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  int bad_hot   = 0;
  int bad_blank = 0;
  int nblank    = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  accu_display #(
    .REFRESH_DIV (REFRESH_DIV),
    .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .out_value  (out_value),
    .state_value(state_value),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] exp_hi(input logic [3:0] h);
    return (LZB && h == 4'h0) ? 7'h7F : hex_tab[h];
  endfunction

  // One clock edge, then sample 1 ns later. The anode monitor runs here.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) begin
      if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7})) bad_hot++;
      if ((an == 4'hF) != ((cyc % 4) == 0)) bad_blank++;
      if (cyc <= 48 && an == 4'hF) nblank++;
    end
  endtask

  task automatic goto_edge(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    out_value   = 8'h00;
    state_value = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_dp", dp, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    goto_edge(1);
    check_eq("e1_an", an, 4'hE);
    check_eq("e1_seg", seg, 7'h40);
    check_eq("e1_dp", dp, 1'b1);
    goto_edge(4);
    check_eq("e4_blank_an", an, 4'hF);
    check_eq("e4_blank_seg", seg, 7'h7F);
    goto_edge(5);
    check_eq("e5_an", an, 4'hD);
    check_eq("e5_seg", seg, exp_hi(4'h0));

    // Assert reset partway through the idx1 slot; outputs must clear at once.
    goto_edge(6);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midrst_an", an, 4'hF);
    check_eq("midrst_seg", seg, 7'h7F);
    check_eq("midrst_dp", dp, 1'b1);
    @(negedge clk);
    reset  = 1'b0;
    cyc    = 0;
    mon_en = 1'b1;

    goto_edge(3);
    check_eq("r2_e3_an", an, 4'hE);
    goto_edge(4);
    check_eq("r2_first_tick", an, 4'hF);

    // Change the inputs mid-frame; the current frame must not change.
    goto_edge(6);
    out_value   = 8'h3A;
    state_value = 4'h2;
    goto_edge(7);
    check_eq("notear_an", an, 4'hD);
    check_eq("notear_seg", seg, exp_hi(4'h0));
    goto_edge(13);
    check_eq("notear_st_an", an, 4'h7);
    check_eq("notear_st_seg", seg, 7'h40);
    check_eq("notear_st_dp", dp, 1'b1);
    goto_edge(17);
    check_eq("cap_idx0_an", an, 4'hE);
    check_eq("cap_idx0_seg", seg, 7'h08);
    goto_edge(21);
    check_eq("cap_idx1_seg", seg, 7'h30);
    goto_edge(25);
    check_eq("cap_idx2_an", an, 4'hB);
    check_eq("cap_idx2_seg", seg, 7'h7F);
    goto_edge(29);
    check_eq("cap_idx3_seg", seg, 7'h24);
    check_eq("flash02_f1_dp", dp, 1'b0);
    goto_edge(33);
    check_eq("flash_idx0_dp", dp, 1'b1);
    goto_edge(45);
    check_eq("flash02_f2_dp", dp, 1'b0);
    goto_edge(61);
    check_eq("flash02_done_dp", dp, 1'b1);

    // Change the state from 2 to 5: dp is lit for two frames, on idx3 only.
    goto_edge(66);
    state_value = 4'h5;
    goto_edge(89);
    check_eq("flash25_idx2_dp", dp, 1'b1);
    goto_edge(93);
    check_eq("st5_seg", seg, 7'h12);
    check_eq("flash25_f1_dp", dp, 1'b0);
    goto_edge(109);
    check_eq("flash25_f2_dp", dp, 1'b0);
    goto_edge(125);
    check_eq("flash25_done_dp", dp, 1'b1);

    // Change to state 7, then to 9 on the frame whose capture would end the flash.
    goto_edge(130);
    state_value = 4'h7;
    goto_edge(157);
    check_eq("rl_f1_dp", dp, 1'b0);
    goto_edge(165);
    state_value = 4'h9;
    goto_edge(173);
    check_eq("rl_f2_seg", seg, 7'h78);
    check_eq("rl_f2_dp", dp, 1'b0);
    goto_edge(189);
    check_eq("rl_f3_seg", seg, 7'h10);
    check_eq("rl_f3_dp", dp, 1'b0);
    goto_edge(205);
    check_eq("rl_f4_dp", dp, 1'b0);
    goto_edge(221);
    check_eq("rl_done_dp", dp, 1'b1);

    // Leading-zero case.
    goto_edge(222);
    out_value = 8'h07;
    goto_edge(225);
    check_eq("lz_idx0_seg", seg, 7'h78);
    goto_edge(229);
    check_eq("lz_idx1_seg", seg, LZB ? 7'h7F : 7'h40);

    // Show every hex value on idx0, idx1 and idx3 (two frames per value).
    for (int v = 0; v < 16; v++) begin
      int base;
      base = 240 + 32 * v;
      goto_edge(base + 2);
      out_value   = {v[3:0], v[3:0]};
      state_value = v[3:0];
      goto_edge(base + 17);
      check_eq($sformatf("hex%0d_idx0", v), seg, hex_tab[v]);
      goto_edge(base + 21);
      check_eq($sformatf("hex%0d_idx1", v), seg, exp_hi(v[3:0]));
      goto_edge(base + 29);
      check_eq($sformatf("hex%0d_idx3", v), seg, hex_tab[v]);
    end

    check_eq("an_onehot_bad", bad_hot, 0);
    check_eq("an_blank_pos_bad", bad_blank, 0);
    check_eq("blanks_3_frames", nblank, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
